aes_gcm_issue_ctrl: RTL and testbench

Front-end sequencer for the AES-GCM encryption pipeline. It accepts one GCM instance at a time (IV, key schedule, AAD/plaintext block counts), then streams AAD and plaintext blocks into the first pipeline stage with the correct phase tag, H seed, J0 and per-block counter block. It inserts bubbles when input data is not available, tracks pipeline occupancy through a fixed-latency drain, and signals completion once the final token has left the pipeline.

---
 rtl/aes_gcm_issue_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_aes_gcm_issue_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_gcm_issue_ctrl.sv
// AES-GCM front-end issue sequencer: latches one GCM instance, streams INIT/AAD/PT/LEN
// tokens into the first pipeline stage, and signals completion after a fixed drain.
module aes_gcm_issue_ctrl #(
    parameter int PIPE_LATENCY = 11,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [95:0]       i_iv,
    input  logic [1407:0]     i_key_schedule,
    input  logic [CNT_W-1:0]  i_aad_blocks,
    input  logic [CNT_W-1:0]  i_pt_blocks,
    input  logic              i_blk_valid,
    input  logic [127:0]      i_blk_data,
    output logic              o_blk_ready,
    output logic [2:0]        o_phase,
    output logic [127:0]      o_plain_text,
    output logic [127:0]      o_aad,
    output logic [127:0]      o_h,
    output logic [127:0]      o_encrypted_j0,
    output logic [127:0]      o_encrypted_cb,
    output logic [127:0]      o_instance_size,
    output logic [1407:0]     o_key_schedule,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_AAD, S_PT, S_LEN, S_DRAIN
    } state_e;

    localparam logic [2:0] PH_BUBBLE = 3'd0;
    localparam logic [2:0] PH_INIT   = 3'd1;
    localparam logic [2:0] PH_AAD    = 3'd2;
    localparam logic [2:0] PH_PT     = 3'd3;
    localparam logic [2:0] PH_LEN    = 3'd4;

    localparam int                 DRAIN_W    = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LATENCY - 1);

    state_e             state_q, state_d;
    logic [95:0]        iv_q, iv_d;
    logic [1407:0]      key_q, key_d;
    logic [CNT_W-1:0]   aad_rem_q, aad_rem_d;
    logic [CNT_W-1:0]   pt_rem_q, pt_rem_d;
    logic [127:0]       size_q, size_d;
    logic [31:0]        ctr_q, ctr_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [2:0]         phase_q, phase_d;
    logic [127:0]       ptxt_q, ptxt_d;
    logic [127:0]       aad_q, aad_d;
    logic [127:0]       j0_q, j0_d;
    logic [127:0]       cb_q, cb_d;
    logic [127:0]       isz_q, isz_d;
    logic [1407:0]      ks_q, ks_d;

    logic               blk_fire;
    logic               issue;

    // Ready decodes registered state only, so it never depends on i_blk_valid.
    assign o_blk_ready = (state_q == S_AAD) || (state_q == S_PT);
    assign blk_fire    = i_blk_valid && o_blk_ready;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d   = state_q;
        iv_d      = iv_q;
        key_d     = key_q;
        aad_rem_d = aad_rem_q;
        pt_rem_d  = pt_rem_q;
        size_d    = size_q;
        ctr_d     = ctr_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        phase_d   = PH_BUBBLE;
        ptxt_d    = '0;
        aad_d     = '0;
        j0_d      = '0;
        cb_d      = '0;
        isz_d     = '0;
        ks_d      = '0;
        issue     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    iv_d      = i_iv;
                    key_d     = i_key_schedule;
                    aad_rem_d = i_aad_blocks;
                    pt_rem_d  = i_pt_blocks;
                    size_d    = {64'(i_aad_blocks) << 7, 64'(i_pt_blocks) << 7};
                    ctr_d     = 32'd2;
                    busy_d    = 1'b1;
                    state_d   = S_INIT;
                end
            end
            S_INIT: begin
                issue   = 1'b1;
                phase_d = PH_INIT;
                if (aad_rem_q != '0)     state_d = S_AAD;
                else if (pt_rem_q != '0) state_d = S_PT;
                else                     state_d = S_LEN;
            end
            S_AAD: begin
                if (blk_fire) begin
                    issue     = 1'b1;
                    phase_d   = PH_AAD;
                    aad_d     = i_blk_data;
                    aad_rem_d = aad_rem_q - CNT_W'(1);
                    if (aad_rem_q == CNT_W'(1)) begin
                        state_d = (pt_rem_q != '0) ? S_PT : S_LEN;
                    end
                end
            end
            S_PT: begin
                if (blk_fire) begin
                    issue    = 1'b1;
                    phase_d  = PH_PT;
                    ptxt_d   = i_blk_data;
                    cb_d     = {iv_q, ctr_q};
                    ctr_d    = ctr_q + 32'd1;  // inc32: wraps in the low word only
                    pt_rem_d = pt_rem_q - CNT_W'(1);
                    if (pt_rem_q == CNT_W'(1)) state_d = S_LEN;
                end
            end
            S_LEN: begin
                issue   = 1'b1;
                phase_d = PH_LEN;
                drain_d = DRAIN_LOAD;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            j0_d  = {iv_q, 32'd1};
            ks_d  = key_q;
            isz_d = size_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            iv_q      <= '0;
            key_q     <= '0;
            aad_rem_q <= '0;
            pt_rem_q  <= '0;
            size_q    <= '0;
            ctr_q     <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            phase_q   <= PH_BUBBLE;
            ptxt_q    <= '0;
            aad_q     <= '0;
            j0_q      <= '0;
            cb_q      <= '0;
            isz_q     <= '0;
            ks_q      <= '0;
        end else begin
            state_q   <= state_d;
            iv_q      <= iv_d;
            key_q     <= key_d;
            aad_rem_q <= aad_rem_d;
            pt_rem_q  <= pt_rem_d;
            size_q    <= size_d;
            ctr_q     <= ctr_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            phase_q   <= phase_d;
            ptxt_q    <= ptxt_d;
            aad_q     <= aad_d;
            j0_q      <= j0_d;
            cb_q      <= cb_d;
            isz_q     <= isz_d;
            ks_q      <= ks_d;
        end
    end

    assign o_phase         = phase_q;
    assign o_plain_text    = ptxt_q;
    assign o_aad           = aad_q;
    assign o_h             = '0;
    assign o_encrypted_j0  = j0_q;
    assign o_encrypted_cb  = cb_q;
    assign o_instance_size = isz_q;
    assign o_key_schedule  = ks_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_aes_gcm_issue_ctrl.sv
// Self-checking bench for aes_gcm_issue_ctrl: token stream compared against a
// block-ordered reference model of one GCM instance.
module tb_aes_gcm_issue_ctrl;

    localparam int L  = 11;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_start;
    logic [95:0]    i_iv;
    logic [1407:0]  i_key_schedule;
    logic [CW-1:0]  i_aad_blocks;
    logic [CW-1:0]  i_pt_blocks;
    logic           i_blk_valid;
    logic [127:0]   i_blk_data;
    logic           o_blk_ready;
    logic [2:0]     o_phase;
    logic [127:0]   o_plain_text, o_aad, o_h, o_encrypted_j0, o_encrypted_cb, o_instance_size;
    logic [1407:0]  o_key_schedule;
    logic           o_busy;
    logic           o_done;

    int n_checks = 0;
    int n_fail   = 0;

    aes_gcm_issue_ctrl #(.PIPE_LATENCY(L), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_iv            (i_iv),
        .i_key_schedule  (i_key_schedule),
        .i_aad_blocks    (i_aad_blocks),
        .i_pt_blocks     (i_pt_blocks),
        .i_blk_valid     (i_blk_valid),
        .i_blk_data      (i_blk_data),
        .o_blk_ready     (o_blk_ready),
        .o_phase         (o_phase),
        .o_plain_text    (o_plain_text),
        .o_aad           (o_aad),
        .o_h             (o_h),
        .o_encrypted_j0  (o_encrypted_j0),
        .o_encrypted_cb  (o_encrypted_cb),
        .o_instance_size (o_instance_size),
        .o_key_schedule  (o_key_schedule),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_all_zero(input string tag);
        n_checks++;
        if (o_phase !== 3'd0 || o_blk_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ctrl: phase=%0d ready=%b busy=%b done=%b required 0 0 0 0",
                     tag, o_phase, o_blk_ready, o_busy, o_done);
        end
        n_checks++;
        if ({o_plain_text, o_aad, o_h, o_encrypted_j0, o_encrypted_cb, o_instance_size} !== '0) begin
            n_fail++;
            $display("FAIL %s fields: any-bit-set=%b required 0", tag,
                     |{o_plain_text, o_aad, o_h, o_encrypted_j0, o_encrypted_cb, o_instance_size});
        end
        n_checks++;
        if (o_key_schedule !== '0) begin
            n_fail++;
            $display("FAIL %s key: low64=%h required 0", tag, o_key_schedule[63:0]);
        end
    endtask

    // Runs one instance of a AAD and p PT blocks. vmode: 0 valid always high,
    // 1 random valid, 2 valid follows pat (MSB first) then high.
    task automatic run_instance(input int a, input int p, input logic [95:0] iv,
                                input int vmode, input logic [5:0] pat,
                                input bit do_wrap, input bit inj, input bit do_rst);
        logic [1407:0] key;
        logic [127:0]  blk[$];
        logic [127:0]  e_aad, e_pt, e_cb, e_size, e_j0;
        logic [31:0]   base, lw;
        logic [2:0]    e_ph;
        bit            v, cons, inj_pt_done, fin, e_busy, e_done, rst_now;
        int            n, c, m, since_len, k;

        n = a + p;
        for (int w = 0; w < 44; w++) key[w*32 +: 32] = $urandom;
        for (int j = 0; j < n; j++) blk.push_back(rand128());
        base   = do_wrap ? 32'hFFFF_FFFF : 32'd2;
        e_size = {64'(a) * 64'd128, 64'(p) * 64'd128};
        e_j0   = {iv, 32'd1};

        @(negedge clk);
        i_start        = 1'b1;
        i_iv           = iv;
        i_key_schedule = key;
        i_aad_blocks   = CW'(a);
        i_pt_blocks    = CW'(p);
        i_blk_valid    = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (o_busy !== 1'b1 || o_phase !== 3'd0 || o_blk_ready !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL accept: busy=%b phase=%0d ready=%b done=%b required 1 0 0 0",
                     o_busy, o_phase, o_blk_ready, o_done);
        end

        c = 0; m = 0; since_len = -1; fin = 0; inj_pt_done = 0;
        while (!fin) begin
            @(negedge clk);
            m++;
            i_start        = 1'b0;
            i_iv           = {$urandom, $urandom, $urandom};
            i_key_schedule = ~key;
            i_aad_blocks   = CW'($urandom);
            i_pt_blocks    = CW'($urandom);
            if (do_wrap && m == 1) force dut.ctr_q = 32'hFFFF_FFFF;
            if (do_wrap && m == 2) release dut.ctr_q;

            cons = 0;
            if (m >= 2 && c < n) begin
                k = m - 2;
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = ($urandom_range(0, 3) != 0);
                    default: v = (k < 6) ? pat[5-k] : 1'b1;
                endcase
                cons = v;
            end else begin
                v = 1'($urandom_range(0, 1));
            end
            i_blk_valid = v;
            i_blk_data  = cons ? blk[c] : rand128();

            if (inj && m >= 2 && c >= a && c < n && !inj_pt_done) begin
                i_start = 1'b1;
                inj_pt_done = 1;
            end
            if (inj && since_len == 4) i_start = 1'b1;
            rst_now = do_rst && cons && (c == a + 1);
            if (rst_now) rst = 1'b1;

            e_busy = 1; e_done = 0; e_ph = 3'd0; e_aad = '0; e_pt = '0; e_cb = '0;
            if (m == 1) begin
                e_ph = 3'd1;
            end else if (c < n) begin
                if (cons) begin
                    if (c < a) begin
                        e_ph  = 3'd2;
                        e_aad = blk[c];
                    end else begin
                        e_ph = 3'd3;
                        e_pt = blk[c];
                        lw   = base + 32'(c - a);
                        e_cb = {iv, lw};
                    end
                end
            end else if (since_len < 0) begin
                e_ph = 3'd4;
                since_len = 0;
            end else begin
                since_len++;
                if (since_len == L) begin
                    e_done = 1; e_busy = 0;
                end else if (since_len > L) begin
                    e_busy = 0; fin = 1;
                end
            end

            @(posedge clk); #1;
            if (rst_now) begin
                check_all_zero("reset_mid");
                rst = 1'b0;
                i_blk_valid = 1'b0;
                fin = 1;
            end else begin
                if (cons) c++;
                n_checks++;
                if (o_phase !== e_ph) begin
                    n_fail++;
                    $display("FAIL phase m=%0d: got %0d required %0d", m, o_phase, e_ph);
                end
                n_checks++;
                if (o_aad !== e_aad || o_plain_text !== e_pt) begin
                    n_fail++;
                    $display("FAIL data m=%0d: aad=%h pt=%h required %h %h", m, o_aad, o_plain_text, e_aad, e_pt);
                end
                n_checks++;
                if (o_encrypted_cb !== e_cb) begin
                    n_fail++;
                    $display("FAIL cb m=%0d: got %h required %h", m, o_encrypted_cb, e_cb);
                end
                n_checks++;
                if (o_busy !== e_busy || o_done !== e_done) begin
                    n_fail++;
                    $display("FAIL busy_done m=%0d: got %b%b required %b%b", m, o_busy, o_done, e_busy, e_done);
                end
                n_checks++;
                if (o_blk_ready !== (c < n) || o_h !== '0) begin
                    n_fail++;
                    $display("FAIL ready_h m=%0d: ready=%b h=%h required %b 0", m, o_blk_ready, o_h, (c < n));
                end
                if (e_ph != 3'd0) begin
                    n_checks++;
                    if (o_encrypted_j0 !== e_j0 || o_key_schedule !== key) begin
                        n_fail++;
                        $display("FAIL j0_key m=%0d: j0=%h key64=%h required %h %h",
                                 m, o_encrypted_j0, o_key_schedule[63:0], e_j0, key[63:0]);
                    end
                end
                if (e_ph == 3'd1 || e_ph == 3'd4) begin
                    n_checks++;
                    if (o_instance_size !== e_size) begin
                        n_fail++;
                        $display("FAIL size m=%0d: got %h required %h", m, o_instance_size, e_size);
                    end
                end
            end
            if (m > 3000) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: instance still running after %0d cycles, required completion", m);
                fin = 1;
            end
        end
        i_blk_valid = 1'b0;
        i_start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("idle");
    endtask

    task automatic test_basic();
        run_instance(2, 3, 96'h1, 0, 6'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        run_instance(0, 0, {$urandom, $urandom, $urandom}, 1, 6'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_cb_wrap();
        run_instance(0, 3, {$urandom, $urandom, $urandom}, 0, 6'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_instance(1, 2, {$urandom, $urandom, $urandom}, 2, 6'b100101, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_instance(2, 3, {$urandom, $urandom, $urandom}, 1, 6'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_instance(2, 3, {$urandom, $urandom, $urandom}, 0, 6'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_phase !== 3'd0) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: done=%b busy=%b phase=%0d required 0 0 0",
                         i, o_done, o_busy, o_phase);
            end
        end
        run_instance(1, 1, {$urandom, $urandom, $urandom}, 0, 6'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            run_instance($urandom_range(0, 5), $urandom_range(0, 5), {$urandom, $urandom, $urandom},
                         1, 6'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        i_start        = 1'b0;
        i_iv           = '0;
        i_key_schedule = '0;
        i_aad_blocks   = '0;
        i_pt_blocks    = '0;
        i_blk_valid    = 1'b0;
        i_blk_data     = '0;
        test_reset();
        test_basic();
        test_empty();
        test_cb_wrap();
        test_stall();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
